// File: rtl/dt_binop_sequencer.sv
// Operator sequencer: pops operands, launches the ALU, pushes the result.
// On underflow or ALU fault the popped words are pushed back before done.
module dt_binop_sequencer #(
  parameter int          DW      = 32,
  parameter logic [1:0]  CMD_NON = 2'b00,
  parameter logic [1:0]  CMD_PUS = 2'b01,
  parameter logic [1:0]  CMD_POP = 2'b10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          start,
  input  logic          unary,
  output logic          busy,
  output logic          done,
  output logic [1:0]    err,
  output logic [1:0]    dt_cmd,
  output logic [DW-1:0] dt_wdata,
  input  logic [DW-1:0] dt_rdata,
  input  logic          dt_ack,
  input  logic          dt_empty,
  output logic [DW-1:0] al_A,
  output logic [DW-1:0] al_B,
  output logic          al_go,
  input  logic [DW-1:0] al_C,
  input  logic          al_done,
  input  logic          al_fault
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHKB,
    S_POPB,
    S_CHKA,
    S_POPA,
    S_EXEC,
    S_WAIT,
    S_PUSH,
    S_RSTA,
    S_RSTB,
    S_FIN
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            un_q;
  logic [1:0]      err_q;
  logic [1:0]      err_n;
  logic [DW-1:0]   a_q;
  logic [DW-1:0]   b_q;
  logic [DW-1:0]   res_q;
  logic            go_q;

  always_comb begin
    state_n  = state;
    err_n    = err_q;
    dt_cmd   = CMD_NON;
    dt_wdata = '0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          err_n   = 2'b00;
          state_n = unary ? S_CHKA : S_CHKB;
        end
      end
      S_CHKB: begin
        if (dt_empty) begin
          err_n   = 2'b01;
          state_n = S_FIN;
        end else begin
          state_n = S_POPB;
        end
      end
      S_POPB: begin
        dt_cmd = CMD_POP;
        if (dt_ack) state_n = S_CHKA;
      end
      S_CHKA: begin
        // Binary underflow must give back the already-popped B.
        if (dt_empty) begin
          err_n   = 2'b01;
          state_n = un_q ? S_FIN : S_RSTB;
        end else begin
          state_n = S_POPA;
        end
      end
      S_POPA: begin
        dt_cmd = CMD_POP;
        if (dt_ack) state_n = S_EXEC;
      end
      S_EXEC: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (al_done) begin
          if (al_fault) begin
            err_n   = 2'b10;
            state_n = S_RSTA;
          end else begin
            state_n = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        dt_cmd   = CMD_PUS;
        dt_wdata = res_q;
        if (dt_ack) state_n = S_FIN;
      end
      S_RSTA: begin
        dt_cmd   = CMD_PUS;
        dt_wdata = a_q;
        if (dt_ack) state_n = un_q ? S_FIN : S_RSTB;
      end
      S_RSTB: begin
        dt_cmd   = CMD_PUS;
        dt_wdata = b_q;
        if (dt_ack) state_n = S_FIN;
      end
      S_FIN: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= S_IDLE;
      err_q <= 2'b00;
      un_q  <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      go_q  <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= err_n;
      go_q  <= (state == S_EXEC);
      if (state == S_IDLE && start) begin
        un_q <= unary;
        a_q  <= '0;
        b_q  <= '0;
      end
      if (state == S_POPB && dt_ack) b_q <= dt_rdata;
      if (state == S_POPA && dt_ack) a_q <= dt_rdata;
      if (state == S_WAIT && al_done && !al_fault) res_q <= al_C;
    end
  end

  assign busy  = (state != S_IDLE) && (state != S_FIN);
  assign done  = (state == S_FIN);
  assign err   = err_q;
  assign al_A  = a_q;
  assign al_B  = b_q;
  assign al_go = go_q;

endmodule

// File: tb/tb_dt_binop_sequencer.sv
// Directed bench: stack and ALU behavioural models around the sequencer.
// Stack acks are combinational; ALU latency is programmable.
module tb_dt_binop_sequencer;
  localparam int DW = 32;
  localparam logic [1:0] NON = 2'b00;
  localparam logic [1:0] PUS = 2'b01;
  localparam logic [1:0] POP = 2'b10;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          start;
  logic          unary;
  logic          busy;
  logic          done;
  logic [1:0]    err;
  logic [1:0]    dt_cmd;
  logic [DW-1:0] dt_wdata;
  logic [DW-1:0] dt_rdata;
  logic          dt_ack;
  logic          dt_empty;
  logic [DW-1:0] al_A;
  logic [DW-1:0] al_B;
  logic          al_go;
  logic [DW-1:0] al_C;
  logic          al_done;
  logic          al_fault;

  logic [DW-1:0] stk [0:7];
  int            depth;
  logic          ack_en;
  int            alu_lat;
  int            cd;
  int            go_cnt, pops, pushes, done_cnt, wd_bad;
  logic [DW-1:0] ga, gb;
  int            total = 0;
  int            bad = 0;
  int            lat;
  logic [1:0]    e;

  always #5 Clock = ~Clock;

  assign dt_ack   = ack_en;
  assign dt_empty = (depth == 0);
  assign dt_rdata = (depth > 0) ? stk[3'(depth - 1)] : '0;

  dt_binop_sequencer #(.DW(DW)) dut (
    .Clock(Clock), .Reset(Reset), .start(start), .unary(unary),
    .busy(busy), .done(done), .err(err),
    .dt_cmd(dt_cmd), .dt_wdata(dt_wdata), .dt_rdata(dt_rdata),
    .dt_ack(dt_ack), .dt_empty(dt_empty),
    .al_A(al_A), .al_B(al_B), .al_go(al_go),
    .al_C(al_C), .al_done(al_done), .al_fault(al_fault)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [1:0]    s_cmd;
    logic          s_ack;
    logic [DW-1:0] s_wd;
    logic          s_go;
    @(negedge Clock);
    s_cmd = dt_cmd;
    s_ack = dt_ack;
    s_wd  = dt_wdata;
    s_go  = al_go;
    if (s_go) begin
      go_cnt++;
      ga = al_A;
      gb = al_B;
    end
    if (done) done_cnt++;
    if (dt_cmd != PUS && dt_wdata != '0) wd_bad++;
    @(posedge Clock);
    #1;
    if (s_ack && Reset) begin
      if (s_cmd == POP && depth > 0) begin
        depth--;
        pops++;
      end else if (s_cmd == PUS && depth < 8) begin
        stk[3'(depth)] = s_wd;
        depth++;
        pushes++;
      end
    end
    al_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) al_done = 1'b1;
    end
    if (s_go) begin
      if (alu_lat == 0) al_done = 1'b1;
      else cd = alu_lat;
    end
  endtask

  task automatic run_op(input logic un, output int l, output logic [1:0] ev);
    go_cnt = 0;
    pops   = 0;
    pushes = 0;
    unary  = un;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    unary  = 1'b0;
    l = 0;
    while (!done && l < 60) begin
      tick();
      l++;
    end
    chk("done_seen", done, 1);
    ev = err;
    tick();
    chk("idle_after_fin", busy, 0);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; unary = 1'b0;
    al_C = '0; al_done = 1'b0; al_fault = 1'b0;
    ack_en = 1'b1; alu_lat = 0; cd = 0; depth = 0;
    go_cnt = 0; pops = 0; pushes = 0; done_cnt = 0; wd_bad = 0;
    ga = '0; gb = '0;
    for (int i = 0; i < 8; i++) stk[i] = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd", dt_cmd, NON);
    chk("rst_wdata", dt_wdata, 0);
    chk("rst_A", al_A, 0);
    chk("rst_B", al_B, 0);
    chk("rst_go", al_go, 0);
    Reset = 1'b1;
    tick();

    // binary ok: [5,3] -> [8]
    stk[0] = 32'd5; stk[1] = 32'd3; depth = 2;
    al_C = 32'd8; al_fault = 1'b0;
    run_op(1'b0, lat, e);
    chk("bin_latency", lat, 8);
    chk("bin_err", e, 2'b00);
    chk("bin_A", ga, 5);
    chk("bin_B", gb, 3);
    chk("bin_go", go_cnt, 1);
    chk("bin_pops", pops, 2);
    chk("bin_depth", depth, 1);
    chk("bin_top", stk[0], 8);

    // unary ok: [7] -> [-7]
    stk[0] = 32'd7; depth = 1;
    al_C = 32'hFFFF_FFF9;
    run_op(1'b1, lat, e);
    chk("un_err", e, 2'b00);
    chk("un_A", ga, 7);
    chk("un_B", gb, 0);
    chk("un_pops", pops, 1);
    chk("un_depth", depth, 1);
    chk("un_top", stk[0], 32'hFFFF_FFF9);

    // underflow on empty stack
    depth = 0;
    run_op(1'b0, lat, e);
    chk("uf0_err", e, 2'b01);
    chk("uf0_pops", pops, 0);
    chk("uf0_pushes", pushes, 0);
    chk("uf0_go", go_cnt, 0);
    chk("uf0_depth", depth, 0);

    // partial underflow: [4] binary, 4 restored
    stk[0] = 32'd4; depth = 1;
    run_op(1'b0, lat, e);
    chk("uf1_err", e, 2'b01);
    chk("uf1_pops", pops, 1);
    chk("uf1_pushes", pushes, 1);
    chk("uf1_go", go_cnt, 0);
    chk("uf1_depth", depth, 1);
    chk("uf1_top", stk[0], 4);

    // ALU fault: [9,0] restored in order
    stk[0] = 32'd9; stk[1] = 32'd0; depth = 2;
    al_C = 32'hDEAD_BEEF; al_fault = 1'b1;
    run_op(1'b0, lat, e);
    chk("flt_err", e, 2'b10);
    chk("flt_go", go_cnt, 1);
    chk("flt_pushes", pushes, 2);
    chk("flt_depth", depth, 2);
    chk("flt_s0", stk[0], 9);
    chk("flt_s1", stk[1], 0);
    al_fault = 1'b0;

    // stall in POPA, then reset while waiting on a slow ALU
    stk[0] = 32'd2; stk[1] = 32'd6; depth = 2;
    alu_lat = 20; ack_en = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    ack_en = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk("stall_cmd", dt_cmd, POP);
      chk("stall_busy", busy, 1);
    end
    chk("stall_depth", depth, 1);
    ack_en = 1'b1;
    tick();
    chk("stall_A", al_A, 2);
    chk("stall_B", al_B, 6);
    tick();
    tick();
    chk("wait_busy", busy, 1);
    chk("wait_done", done, 0);
    Reset = 1'b0;
    tick();
    chk("mrst_busy", busy, 0);
    chk("mrst_cmd", dt_cmd, NON);
    chk("mrst_A", al_A, 0);
    chk("mrst_B", al_B, 0);
    chk("mrst_go", al_go, 0);
    chk("mrst_err", err, 0);
    Reset = 1'b1;
    done_cnt = 0;
    repeat (25) tick();
    chk("late_done_ignored", done_cnt, 0);
    chk("late_busy", busy, 0);
    chk("no_restore_depth", depth, 0);
    chk("wdata_zero_when_idle", wd_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
